// File: rtl/rb_write_queue.sv
// rb_write_queue
//   Writer-side front end for the 32x32 register bank. Write requests from the
//   writeback path are buffered in a small FIFO. The FIFO drains into the bank's
//   EnW/AW/DW port at most once per clock. Two combinational forwarding lookups
//   let readers see values that are still pending and not yet in the bank.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   wr_valid/wr_ready          request handshake (wr_ready = count < DEPTH)
//   wr_addr/wr_data            destination register and value
//   hold                       1 = stop draining; pushes are still accepted
//   rb_en/rb_addr/rb_data      registered bank write port (rb_en is a 1-cycle pulse)
//   lkN_addr/lkN_hit/lkN_data  forwarding lookups (youngest pending value, 0 on miss)
//   count                      number of entries currently queued

module rb_write_queue #(
  parameter int DEPTH = 4,
  parameter int A_W   = 5,
  parameter int D_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [A_W-1:0]           wr_addr,
  input  logic [D_W-1:0]           wr_data,
  input  logic                     hold,
  output logic                     rb_en,
  output logic [A_W-1:0]           rb_addr,
  output logic [D_W-1:0]           rb_data,
  input  logic [A_W-1:0]           lk1_addr,
  output logic                     lk1_hit,
  output logic [D_W-1:0]           lk1_data,
  input  logic [A_W-1:0]           lk2_addr,
  output logic                     lk2_hit,
  output logic [D_W-1:0]           lk2_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [A_W-1:0]   addr_q [DEPTH];
  logic [D_W-1:0]   data_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rb_en_q, rb_en_d;
  logic [A_W-1:0]   rb_addr_q, rb_addr_d;
  logic [D_W-1:0]   rb_data_q, rb_data_d;

  logic             push, pop;
  logic [PTR_W-1:0] lk_idx;

  // No full bypass: a pop in the same cycle does not make room for a push.
  assign wr_ready = (count_q != CNT_W'(DEPTH));
  assign push     = wr_valid & wr_ready;
  assign pop      = (count_q != '0) & ~hold;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rb_en_d   = pop;
    rb_addr_d = rb_addr_q;
    rb_data_d = rb_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rb_addr_d = addr_q[rd_ptr_q];
      rb_data_d = data_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rb_en_q   <= 1'b0;
      rb_addr_q <= '0;
      rb_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rb_en_q   <= rb_en_d;
      rb_addr_q <= rb_addr_d;
      rb_data_q <= rb_data_d;
    end
  end

  // Storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= wr_addr;
      data_q[wr_ptr_q] <= wr_data;
    end
  end

  // Scan from oldest to youngest so the last match wins. The output stage is
  // older than every queued entry, so it seeds the result.
  always_comb begin
    lk_idx   = '0;
    lk1_hit  = rb_en_q && (rb_addr_q == lk1_addr);
    lk1_data = lk1_hit ? rb_data_q : '0;
    lk2_hit  = rb_en_q && (rb_addr_q == lk2_addr);
    lk2_data = lk2_hit ? rb_data_q : '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (addr_q[lk_idx] == lk1_addr) begin
          lk1_hit  = 1'b1;
          lk1_data = data_q[lk_idx];
        end
        if (addr_q[lk_idx] == lk2_addr) begin
          lk2_hit  = 1'b1;
          lk2_data = data_q[lk_idx];
        end
      end
    end
  end

  assign rb_en   = rb_en_q;
  assign rb_addr = rb_addr_q;
  assign rb_data = rb_data_q;
  assign count   = count_q;

endmodule
